// File: rtl/alu_core_if.sv
// alu_core_if: operand/opcode/result bundle for the registered integer ALU.
// The master drives operands and the opcode and receives the registered
// result and flag. The slave is the ALU itself.
interface alu_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic [3:0]            in_mode;
  logic [DATA_WIDTH-1:0] out_alu;
  logic                  cout;

  modport master (
    output in_a,
    output in_b,
    output in_mode,
    input  out_alu,
    input  cout
  );

  modport slave (
    input  in_a,
    input  in_b,
    input  in_mode,
    output out_alu,
    output cout
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: registered, parameterised unsigned integer ALU, 16 opcodes.
// Opcode decode is purely combinational and feeds a single output register,
// so a result appears one clock after its operands are sampled and a new
// operation can start every cycle.
//
// Optional feature macro: ALU_DIV_EN
//   defined   -> opcode 3 is a combinational divide (b==0 gives all ones, cout=1)
//   undefined -> no divider is built; opcode 3 returns 0 with cout=0
module alu_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  alu_core_if.slave  bus
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NOR  = 4'd11,
    OP_NAND = 4'd12,
    OP_XNOR = 4'd13,
    OP_GT   = 4'd14,
    OP_EQ   = 4'd15
  } alu_op_e;

  logic [W-1:0]   a;
  logic [W-1:0]   b;
  alu_op_e        op;

  // Arithmetic sub-results, each one bit (or W bits) wider than the result
  // so the flag falls out of the top part directly.
  logic [W:0]     sum_ext;
  logic [W:0]     diff_ext;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quot;
  logic           div_by_zero;

  logic [W-1:0]   res_d;
  logic           cout_d;

  assign a  = bus.in_a;
  assign b  = bus.in_b;
  assign op = alu_op_e'(bus.in_mode);

  // Shared adder/subtractor/multiplier; bit W of the subtract is the borrow.
  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    prod     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  end

`ifdef ALU_DIV_EN
  // Combinational divider; the zero-divisor case is steered away from the
  // divide so the quotient never depends on a/0.
  always_comb begin
    div_by_zero = (b == '0);
    quot        = '1;
    if (!div_by_zero) quot = a / b;
  end
`else
  // Divide disabled: opcode 3 collapses to a constant zero.
  always_comb begin
    div_by_zero = 1'b0;
    quot        = '0;
  end
`endif

  // Opcode decode: every opcode plus a default drives both outputs so no X
  // can reach the register even for an undriven opcode.
  always_comb begin
    res_d  = '0;
    cout_d = 1'b0;
    case (op)
      OP_ADD: begin
        res_d  = sum_ext[W-1:0];
        cout_d = sum_ext[W];
      end
      OP_SUB: begin
        res_d  = diff_ext[W-1:0];
        cout_d = diff_ext[W];
      end
      OP_MUL: begin
        res_d  = prod[W-1:0];
        cout_d = |prod[2*W-1:W];
      end
      OP_DIV: begin
        res_d  = quot;
        cout_d = div_by_zero;
      end
      OP_SHL: begin
        res_d  = {a[W-2:0], 1'b0};
        cout_d = a[W-1];
      end
      OP_SHR: begin
        res_d  = {1'b0, a[W-1:1]};
        cout_d = a[0];
      end
      OP_ROL: begin
        res_d  = {a[W-2:0], a[W-1]};
        cout_d = a[W-1];
      end
      OP_ROR: begin
        res_d  = {a[0], a[W-1:1]};
        cout_d = a[0];
      end
      OP_AND:  res_d = a & b;
      OP_OR:   res_d = a | b;
      OP_XOR:  res_d = a ^ b;
      OP_NOR:  res_d = ~(a | b);
      OP_NAND: res_d = ~(a & b);
      OP_XNOR: res_d = ~(a ^ b);
      OP_GT:   res_d = {{(W-1){1'b0}}, (a > b)};
      OP_EQ:   res_d = {{(W-1){1'b0}}, (a == b)};
      default: begin
        res_d  = '0;
        cout_d = 1'b0;
      end
    endcase
  end

  // Output register; synchronous reset wins over any operation that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_alu <= '0;
      bus.cout    <= 1'b0;
    end else begin
      bus.out_alu <= res_d;
      bus.cout    <= cout_d;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: self-checking bench for alu_core (DATA_WIDTH = 8).
// Directed boundary vectors plus a randomized opcode sweep checked against
// an arithmetic reference model. Honours ALU_DIV_EN the same way the design does.
module tb_alu_core;

  localparam int W = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_core_if #(.DATA_WIDTH(W)) bus ();

  alu_core #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on 0..255 values.
  // Returns {cout, result}.
  function automatic logic [W:0] ref_alu(input int a, input int b, input int m);
    int r;
    int c;
    r = 0;
    c = 0;
    case (m)
      0:  begin r = (a + b) % 256;       c = (a + b > 255) ? 1 : 0; end
      1:  begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2:  begin r = (a * b) % 256;       c = (a * b > 255) ? 1 : 0; end
      3: begin
`ifdef ALU_DIV_EN
        if (b == 0) begin r = 255; c = 1; end
        else        begin r = a / b; c = 0; end
`else
        r = 0; c = 0;
`endif
      end
      4:  begin r = (a * 2) % 256;           c = a / 128; end
      5:  begin r = a / 2;                   c = a % 2; end
      6:  begin r = (a * 2) % 256 + a / 128; c = a / 128; end
      7:  begin r = a / 2 + (a % 2) * 128;   c = a % 2; end
      8:  r = a & b;
      9:  r = a | b;
      10: r = a ^ b;
      11: r = 255 - (a | b);
      12: r = 255 - (a & b);
      13: r = 255 - (a ^ b);
      14: r = (a > b) ? 1 : 0;
      15: r = (a == b) ? 1 : 0;
      default: r = 0;
    endcase
    return {c[0], r[W-1:0]};
  endfunction

  // Drive one operation and advance to just after the capturing edge.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] m);
    bus.in_a    = a;
    bus.in_b    = b;
    bus.in_mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(8'hFF, 8'hFF, 4'd0);
    step(8'hFF, 8'hFF, 4'd0);
    checks++;
    if (bus.out_alu !== 8'h00 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL reset: got out=%h cout=%b want out=00 cout=0", bus.out_alu, bus.cout);
    end
    reset = 1'b0;
    step(8'hFF, 8'hFF, 4'd0);
    checks++;
    if (bus.out_alu !== 8'hFE || bus.cout !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got out=%h cout=%b want out=fe cout=1", bus.out_alu, bus.cout);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [0:18];
    logic [W-1:0] vb [0:18];
    logic [3:0]   vm [0:18];
    logic [W-1:0] er [0:18];
    logic         ec [0:18];
    // ADD/SUB
    va[0]=8'hFF; vb[0]=8'h01; vm[0]=4'd0;  er[0]=8'h00; ec[0]=1'b1;
    va[1]=8'h05; vb[1]=8'h07; vm[1]=4'd1;  er[1]=8'hFE; ec[1]=1'b1;
    va[2]=8'h07; vb[2]=8'h05; vm[2]=4'd1;  er[2]=8'h02; ec[2]=1'b0;
    // MUL/DIV
    va[3]=8'h10; vb[3]=8'h10; vm[3]=4'd2;  er[3]=8'h00; ec[3]=1'b1;
    va[4]=8'h0C; vb[4]=8'h03; vm[4]=4'd2;  er[4]=8'h24; ec[4]=1'b0;
`ifdef ALU_DIV_EN
    va[5]=8'hC8; vb[5]=8'h07; vm[5]=4'd3;  er[5]=8'h1C; ec[5]=1'b0;
    va[6]=8'h55; vb[6]=8'h00; vm[6]=4'd3;  er[6]=8'hFF; ec[6]=1'b1;
`else
    va[5]=8'hC8; vb[5]=8'h07; vm[5]=4'd3;  er[5]=8'h00; ec[5]=1'b0;
    va[6]=8'h55; vb[6]=8'h00; vm[6]=4'd3;  er[6]=8'h00; ec[6]=1'b0;
`endif
    // Shifts/rotates
    va[7]=8'h81;  vb[7]=8'h5A;  vm[7]=4'd4;  er[7]=8'h02;  ec[7]=1'b1;
    va[8]=8'h81;  vb[8]=8'h5A;  vm[8]=4'd5;  er[8]=8'h40;  ec[8]=1'b1;
    va[9]=8'h81;  vb[9]=8'h5A;  vm[9]=4'd6;  er[9]=8'h03;  ec[9]=1'b1;
    va[10]=8'h81; vb[10]=8'h5A; vm[10]=4'd7; er[10]=8'hC0; ec[10]=1'b1;
    // Logic/compare
    va[11]=8'hF0; vb[11]=8'h3C; vm[11]=4'd8;  er[11]=8'h30; ec[11]=1'b0;
    va[12]=8'hF0; vb[12]=8'h3C; vm[12]=4'd9;  er[12]=8'hFC; ec[12]=1'b0;
    va[13]=8'hF0; vb[13]=8'h3C; vm[13]=4'd10; er[13]=8'hCC; ec[13]=1'b0;
    va[14]=8'hF0; vb[14]=8'h3C; vm[14]=4'd11; er[14]=8'h03; ec[14]=1'b0;
    va[15]=8'hF0; vb[15]=8'h3C; vm[15]=4'd12; er[15]=8'hCF; ec[15]=1'b0;
    va[16]=8'hF0; vb[16]=8'h3C; vm[16]=4'd13; er[16]=8'h33; ec[16]=1'b0;
    va[17]=8'hF0; vb[17]=8'h3C; vm[17]=4'd14; er[17]=8'h01; ec[17]=1'b0;
    va[18]=8'h3C; vb[18]=8'h3C; vm[18]=4'd15; er[18]=8'h01; ec[18]=1'b0;
    for (int i = 0; i < 19; i++) begin
      step(va[i], vb[i], vm[i]);
      checks++;
      if (bus.out_alu !== er[i] || bus.cout !== ec[i]) begin
        errors++;
        $display("FAIL directed[%0d] mode=%0d a=%h b=%h: got out=%h cout=%b want out=%h cout=%b",
                 i, vm[i], va[i], vb[i], bus.out_alu, bus.cout, er[i], ec[i]);
      end
    end
    // EQ false case with unequal operands
    step(8'hF0, 8'h3C, 4'd15);
    checks++;
    if (bus.out_alu !== 8'h00 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL eq_false: got out=%h cout=%b want out=00 cout=0", bus.out_alu, bus.cout);
    end
  endtask

  // Randomized sweep: two fresh vectors per opcode, inputs changing every
  // cycle; each result must match the model exactly one edge later.
  task automatic test_sweep();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   exp;
    for (int m = 0; m < 16; m++) begin
      for (int k = 0; k < 2; k++) begin
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
        if (k == 1 && m == 3) b = 8'h00;
        exp = ref_alu(int'(a), int'(b), m);
        step(a, b, 4'(m));
        checks++;
        if (bus.out_alu !== exp[W-1:0] || bus.cout !== exp[W]) begin
          errors++;
          $display("FAIL sweep mode=%0d a=%h b=%h: got out=%h cout=%b want out=%h cout=%b",
                   m, a, b, bus.out_alu, bus.cout, exp[W-1:0], exp[W]);
        end
      end
    end
  endtask

  // Back-to-back: after a result is captured, new inputs are applied at
  // once; the output must hold the old result until the next edge.
  task automatic test_back_to_back();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   m;
    logic [W:0]   exp;
    logic [W:0]   prev;
    prev = '0;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      m = 4'($urandom_range(0, 15));
      exp = ref_alu(int'(a), int'(b), int'(m));
      bus.in_a    = a;
      bus.in_b    = b;
      bus.in_mode = m;
      if (i > 0) begin
        #2;
        checks++;
        if (bus.out_alu !== prev[W-1:0] || bus.cout !== prev[W]) begin
          errors++;
          $display("FAIL hold[%0d]: got out=%h cout=%b want out=%h cout=%b",
                   i, bus.out_alu, bus.cout, prev[W-1:0], prev[W]);
        end
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_alu !== exp[W-1:0] || bus.cout !== exp[W]) begin
        errors++;
        $display("FAIL b2b[%0d] mode=%0d a=%h b=%h: got out=%h cout=%b want out=%h cout=%b",
                 i, m, a, b, bus.out_alu, bus.cout, exp[W-1:0], exp[W]);
      end
      prev = exp;
    end
  endtask

  // Reset asserted mid-stream overrides the operation in that cycle.
  task automatic test_reset_override();
    reset = 1'b1;
    step(8'hFF, 8'h01, 4'd0);
    checks++;
    if (bus.out_alu !== 8'h00 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_override: got out=%h cout=%b want out=00 cout=0", bus.out_alu, bus.cout);
    end
    reset = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    bus.in_a    = '0;
    bus.in_b    = '0;
    bus.in_mode = '0;
    test_reset();
    test_directed();
    test_sweep();
    test_back_to_back();
    test_reset_override();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
